// File: rtl/main_dec.sv
// Main control decoder for the single-cycle LEGv8 datapath: decodes the 11-bit
// opcode into registered datapath control strobes, one cycle after Op is sampled.
module main_dec (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] Op,
    output logic        Reg2Loc,
    output logic        ALUSrc,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        Branch,
    output logic [1:0]  ALUOp
);

    typedef enum logic [1:0] {
        ALUOP_ADD  = 2'b00,
        ALUOP_PASS = 2'b01,
        ALUOP_RTYP = 2'b10
    } aluop_e;

    typedef struct packed {
        logic   reg2loc;
        logic   alusrc;
        logic   memtoreg;
        logic   regwrite;
        logic   memread;
        logic   memwrite;
        logic   branch;
        aluop_e aluop;
    } ctrl_t;

    localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
    localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
    localparam logic [7:0]  OP_CBZ  = 8'b1011_0100;
    localparam logic [10:0] OP_ADD  = 11'b100_0101_1000;
    localparam logic [10:0] OP_SUB  = 11'b110_0101_1000;
    localparam logic [10:0] OP_AND  = 11'b100_0101_0000;
    localparam logic [10:0] OP_ORR  = 11'b101_0101_0000;

    localparam ctrl_t CTRL_NOP = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_ADD};

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    // Equality compares (not casez) so an X/Z opcode bit never matches and falls to NOP.
    always_comb begin
        // NOTE: default assigned first so every path drives ctrl_d and no latch is inferred.
        ctrl_d = CTRL_NOP;
        if (Op == OP_LDUR) begin
            ctrl_d = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ALUOP_ADD};
        end else if (Op == OP_STUR) begin
            ctrl_d = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALUOP_ADD};
        end else if (Op[10:3] == OP_CBZ) begin
            ctrl_d = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_PASS};
        end else if (Op == OP_ADD || Op == OP_SUB || Op == OP_AND || Op == OP_ORR) begin
            ctrl_d = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALUOP_RTYP};
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment for flop state avoids simulation race ordering.
        if (reset) begin
            ctrl_q <= CTRL_NOP;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign Reg2Loc  = ctrl_q.reg2loc;
    assign ALUSrc   = ctrl_q.alusrc;
    assign MemtoReg = ctrl_q.memtoreg;
    assign RegWrite = ctrl_q.regwrite;
    assign MemRead  = ctrl_q.memread;
    assign MemWrite = ctrl_q.memwrite;
    assign Branch   = ctrl_q.branch;
    assign ALUOp    = ctrl_q.aluop;

endmodule

// File: tb/tb_main_dec.sv
// Directed bench for main_dec: expected control words are queued when an opcode is
// driven on the falling edge and popped/compared 1 time unit after the rising edge.
module tb_main_dec;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] Op;
    logic        Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch;
    logic [1:0]  ALUOp;

    int checks = 0;
    int errors = 0;

    logic [8:0] sb[$];
    logic [8:0] last_exp;
    bit         have_last = 1'b0;

    // Control word order: Reg2Loc ALUSrc MemtoReg RegWrite MemRead MemWrite Branch ALUOp
    localparam logic [8:0] E_LDUR = 9'b0111100_00;
    localparam logic [8:0] E_STUR = 9'b1100010_00;
    localparam logic [8:0] E_CBZ  = 9'b1000001_01;
    localparam logic [8:0] E_RTYP = 9'b0001000_10;
    localparam logic [8:0] E_NOP  = 9'b0000000_00;

    main_dec dut (
        .clk      (clk),
        .reset    (reset),
        .Op       (Op),
        .Reg2Loc  (Reg2Loc),
        .ALUSrc   (ALUSrc),
        .MemtoReg (MemtoReg),
        .RegWrite (RegWrite),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .Branch   (Branch),
        .ALUOp    (ALUOp)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] outs();
        return {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp};
    endfunction

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    // One directed step: verify the previous word held to the falling edge, drive,
    // queue the expectation, then compare just after the rising edge.
    task automatic step(input string tag, input logic r, input logic [10:0] op,
                        input logic [8:0] exp);
        logic [8:0] e;
        @(negedge clk);
        if (have_last) check({tag, "_hold"}, outs(), last_exp);
        reset = r;
        Op    = op;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            check(tag, outs(), e);
            last_exp  = e;
            have_last = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b1;
        Op    = 11'b111_1100_0010;

        step("reset0",    1'b1, 11'b111_1100_0010, E_NOP);
        step("reset1",    1'b1, 11'b111_1100_0010, E_NOP);
        step("ldur",      1'b0, 11'b111_1100_0010, E_LDUR);
        step("stur",      1'b0, 11'b111_1100_0000, E_STUR);
        step("cbz_000",   1'b0, 11'b101_1010_0000, E_CBZ);
        step("cbz_111",   1'b0, 11'b101_1010_0111, E_CBZ);
        step("add",       1'b0, 11'b100_0101_1000, E_RTYP);
        step("sub",       1'b0, 11'b110_0101_1000, E_RTYP);
        step("and",       1'b0, 11'b100_0101_0000, E_RTYP);
        step("orr",       1'b0, 11'b101_0101_0000, E_RTYP);
        step("zero",      1'b0, 11'b000_0000_0000, E_NOP);
        step("ones",      1'b0, 11'b111_1111_1111, E_NOP);
        step("ldur_2",    1'b0, 11'b111_1100_0010, E_LDUR);
        step("rst_add",   1'b1, 11'b100_0101_1000, E_NOP);
        step("add_after", 1'b0, 11'b100_0101_1000, E_RTYP);
        step("near_cbz",  1'b0, 11'b101_1010_1000, E_NOP);
        step("near_ldur", 1'b0, 11'b111_1100_0011, E_NOP);
        step("near_add",  1'b0, 11'b100_0101_1001, E_NOP);
        step("near_stur", 1'b0, 11'b111_1100_1000, E_NOP);
        step("stur_2",    1'b0, 11'b111_1100_0000, E_STUR);
        step("cbz_101",   1'b0, 11'b101_1010_0101, E_CBZ);
        step("orr_2",     1'b0, 11'b101_0101_0000, E_RTYP);

        @(negedge clk);
        check("final_hold", outs(), last_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
